hdmi_src_sched: RTL and testbench

Frame-synchronous pixel-source scheduler between the HDMI transmitter's pixel-request interface and up to four pixel sources (test-pattern generators, framebuffer readers). It fans the transmitter's `req_*` strobes out to exactly one selected source and muxes that source's `resp_*` back, aligned to `RESP_LATENCY`. Source changes requested through a valid/ready config port take effect only on a frame boundary (`req_sof`), so no frame ever mixes two sources.

---
 rtl/hdmi_src_sched_pkg.sv | 18 +
 rtl/hdmi_sel_pipe.sv | 30 +++
 rtl/hdmi_src_sched.sv | 147 ++++++++++++++
 tb/tb_hdmi_src_sched.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_src_sched_pkg.sv
// Shared types and constants for the HDMI pixel-source scheduler.
package hdmi_src_sched_pkg;

    localparam int SRC_W = 3;
    localparam logic [SRC_W-1:0] SRC_BLANK = 3'd7;

    typedef enum logic [1:0] {
        ST_BLANK,
        ST_RUN,
        ST_PEND
    } sched_state_e;

    // Any index at or beyond the number of attached sources folds to blank.
    function automatic logic [SRC_W-1:0] norm_src(input logic [SRC_W-1:0] src, input int nsrc);
        return (int'(src) < nsrc) ? src : SRC_BLANK;
    endfunction

endpackage

// File: rtl/hdmi_sel_pipe.sv
// Select delay line matching the source response latency; entries reset to blank.
module hdmi_sel_pipe
    import hdmi_src_sched_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [SRC_W-1:0] sel_in,
    output logic [SRC_W-1:0] sel_tail
);

    logic [SRC_W-1:0] stages [DEPTH];

    // NOTE: this small array is reset on purpose so no stale select can
    // route a leftover pixel after reset; large data memories would not be.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) stages[i] <= SRC_BLANK;
        end else begin
            // NOTE: non-blocking assignments make every stage shift from the
            // pre-edge values, independent of statement order.
            stages[0] <= sel_in;
            for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
        end
    end

    assign sel_tail = stages[DEPTH-1];

endmodule

// File: rtl/hdmi_src_sched.sv
// Frame-synchronous pixel-source scheduler. Optional statistics counters are
// built only when HDMI_SRC_SCHED_STATS_EN is defined.
module hdmi_src_sched
    import hdmi_src_sched_pkg::*;
#(
    parameter int RESP_LATENCY = 1,
    parameter int NSRC         = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [2:0]        cfg_src,
    output logic              sw_done,
    output logic [2:0]        cur_src,
    input  logic              req_en,
    input  logic              req_sof,
    input  logic              req_sol,
    output logic [7:0]        resp_red,
    output logic [7:0]        resp_green,
    output logic [7:0]        resp_blue,
    output logic [NSRC-1:0]   src_req_en,
    output logic [NSRC-1:0]   src_req_sof,
    output logic [NSRC-1:0]   src_req_sol,
    input  logic [8*NSRC-1:0] src_resp_red,
    input  logic [8*NSRC-1:0] src_resp_green,
    input  logic [8*NSRC-1:0] src_resp_blue,
    output logic [15:0]       frame_cnt,
    output logic [7:0]        switch_cnt
);

    sched_state_e     state, state_nxt;
    logic [SRC_W-1:0] cur_q, cur_nxt, pend_q, pend_nxt;
    logic [SRC_W-1:0] cfg_tgt, sel_eff, sel_tail, pipe_in;
    logic             done_q, done_nxt, sof_hit;

    assign cfg_tgt = norm_src(cfg_src, NSRC);
    assign sof_hit = req_en && req_sof;

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_nxt = state;
        cur_nxt   = cur_q;
        pend_nxt  = pend_q;
        done_nxt  = 1'b0;
        cfg_ready = 1'b0;
        sel_eff   = cur_q;
        case (state)
            ST_BLANK, ST_RUN: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    if (cfg_tgt == cur_q) begin
                        done_nxt = 1'b1;
                    end else begin
                        pend_nxt  = cfg_tgt;
                        state_nxt = ST_PEND;
                    end
                end
            end
            ST_PEND: begin
                // The sof pixel itself already goes to the new source.
                if (sof_hit) begin
                    sel_eff   = pend_q;
                    cur_nxt   = pend_q;
                    done_nxt  = 1'b1;
                    state_nxt = (pend_q == SRC_BLANK) ? ST_BLANK : ST_RUN;
                end
            end
            default: state_nxt = ST_BLANK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state  <= ST_BLANK;
            cur_q  <= SRC_BLANK;
            pend_q <= SRC_BLANK;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cur_q  <= cur_nxt;
            pend_q <= pend_nxt;
            done_q <= done_nxt;
        end
    end

    assign sw_done = done_q;
    assign cur_src = cur_q;

    always_comb begin
        src_req_en  = '0;
        src_req_sof = '0;
        src_req_sol = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (int'(sel_eff) == i) begin
                src_req_en[i]  = req_en;
                src_req_sof[i] = req_sof;
                src_req_sol[i] = req_sol;
            end
        end
    end

    // Idle slots carry blank so they return black, like a blank source.
    assign pipe_in = req_en ? sel_eff : SRC_BLANK;

    hdmi_sel_pipe #(.DEPTH(RESP_LATENCY)) u_sel_pipe (
        .clk      (clk),
        .rstn     (rstn),
        .sel_in   (pipe_in),
        .sel_tail (sel_tail)
    );

    // Gated by rstn so the output is black from the very first reset cycle.
    always_comb begin
        resp_red   = '0;
        resp_green = '0;
        resp_blue  = '0;
        if (rstn && int'(sel_tail) < NSRC) begin
            resp_red   = src_resp_red[int'(sel_tail)*8 +: 8];
            resp_green = src_resp_green[int'(sel_tail)*8 +: 8];
            resp_blue  = src_resp_blue[int'(sel_tail)*8 +: 8];
        end
    end

`ifdef HDMI_SRC_SCHED_STATS_EN
    logic [15:0] frame_q;
    logic [7:0]  switch_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            frame_q  <= '0;
            switch_q <= '0;
        end else begin
            if (sof_hit) frame_q <= frame_q + 16'd1;
            if (done_q && switch_q != 8'hFF) switch_q <= switch_q + 8'd1;
        end
    end

    assign frame_cnt  = frame_q;
    assign switch_cnt = switch_q;
`else
    assign frame_cnt  = '0;
    assign switch_cnt = '0;
`endif

endmodule

// File: tb/tb_hdmi_src_sched.sv
// Randomized bench for hdmi_src_sched against a per-cycle behavioural model.
module tb_hdmi_src_sched;

    localparam int LAT  = 3;
    localparam int NSRC = 2;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              cfg_valid = 1'b0;
    logic [2:0]        cfg_src = '0;
    logic              req_en = 1'b0, req_sof = 1'b0, req_sol = 1'b0;
    logic [8*NSRC-1:0] src_resp_red = '0, src_resp_green = '0, src_resp_blue = '0;
    logic              cfg_ready, sw_done;
    logic [2:0]        cur_src;
    logic [7:0]        resp_red, resp_green, resp_blue;
    logic [NSRC-1:0]   src_req_en, src_req_sof, src_req_sol;
    logic [15:0]       frame_cnt;
    logic [7:0]        switch_cnt;

    hdmi_src_sched #(.RESP_LATENCY(LAT), .NSRC(NSRC)) dut (
        .clk(clk), .rstn(rstn),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_src(cfg_src),
        .sw_done(sw_done), .cur_src(cur_src),
        .req_en(req_en), .req_sof(req_sof), .req_sol(req_sol),
        .resp_red(resp_red), .resp_green(resp_green), .resp_blue(resp_blue),
        .src_req_en(src_req_en), .src_req_sof(src_req_sof), .src_req_sol(src_req_sol),
        .src_resp_red(src_resp_red), .src_resp_green(src_resp_green),
        .src_resp_blue(src_resp_blue),
        .frame_cnt(frame_cnt), .switch_cnt(switch_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit rand_data = 1'b0;

    // Reference model: routed source (7 = blank), pending target (-1 = none),
    // per-request history of which source answers, and statistics.
    int m_cur, m_pend, m_frames, m_switches;
    bit m_done;
    int m_hist[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cur = 7; m_pend = -1; m_done = 0; m_frames = 0; m_switches = 0;
        m_hist = {};
        repeat (LAT) m_hist.push_back(7);
    endtask

    function automatic int pick(input logic [8*NSRC-1:0] bus, input int s);
        return (s < NSRC) ? int'(bus[8*s +: 8]) : 0;
    endfunction

    // Inputs are already driven (after a falling edge); check, then advance.
    task automatic tick();
        int eff, tail, tgt, exp_frames, exp_switches;
        bit hit, done_next;
        logic [NSRC-1:0] mask;
        if (rand_data) begin
            src_resp_red   = NSRC*8'($urandom);
            src_resp_green = NSRC*8'($urandom);
            src_resp_blue  = NSRC*8'($urandom);
        end
        #1;
        tail = m_hist[0];
        if (!rstn) begin
            check("resp_red_rst", resp_red, 0);
            check("resp_green_rst", resp_green, 0);
            check("resp_blue_rst", resp_blue, 0);
            @(posedge clk);
            model_reset();
            @(negedge clk);
            return;
        end
        hit  = req_en && req_sof;
        eff  = (m_pend >= 0 && hit) ? m_pend : m_cur;
        mask = (eff < NSRC) ? NSRC'(1 << eff) : '0;
`ifdef HDMI_SRC_SCHED_STATS_EN
        exp_frames = m_frames; exp_switches = m_switches;
`else
        exp_frames = 0; exp_switches = 0;
`endif
        check("cfg_ready", cfg_ready, m_pend < 0);
        check("sw_done", sw_done, m_done);
        check("cur_src", cur_src, m_cur);
        check("src_req_en", src_req_en, req_en ? mask : '0);
        check("src_req_sof", src_req_sof, req_sof ? mask : '0);
        check("src_req_sol", src_req_sol, req_sol ? mask : '0);
        check("resp_red", resp_red, pick(src_resp_red, tail));
        check("resp_green", resp_green, pick(src_resp_green, tail));
        check("resp_blue", resp_blue, pick(src_resp_blue, tail));
        check("frame_cnt", frame_cnt, exp_frames);
        check("switch_cnt", switch_cnt, exp_switches);
        @(posedge clk);
        done_next = 0;
        if (cfg_valid && m_pend < 0) begin
            tgt = (cfg_src < NSRC) ? int'(cfg_src) : 7;
            if (tgt == m_cur) done_next = 1;
            else m_pend = tgt;
        end else if (m_pend >= 0 && hit) begin
            m_cur = m_pend; m_pend = -1; done_next = 1;
        end
        m_hist.push_back(req_en ? eff : 7);
        void'(m_hist.pop_front());
        if (hit) m_frames = (m_frames + 1) % 65536;
        if (m_done && m_switches < 255) m_switches++;
        m_done = done_next;
        @(negedge clk);
    endtask

    task automatic drive(input bit en, input bit sof, input bit sol, input bit cv, input int cs);
        req_en = en; req_sof = sof; req_sol = sol;
        cfg_valid = cv; cfg_src = 3'(cs);
        tick();
    endtask

    // One frame of w x h pixels; optional cfg request at pixel index cfg_at.
    task automatic frame(input int w, input int h, input int cfg_at, input int cs, input bit gaps);
        int k = 0;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                drive(1, (x == 0 && y == 0), (x == 0), (k == cfg_at), cs);
                k++;
            end
            if (gaps && y != h - 1) drive(0, 0, 0, 0, 0);
        end
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        rstn = 1'b1;
        src_resp_red   = {8'h55, 8'hAA};
        src_resp_green = {8'h55, 8'hAA};
        src_resp_blue  = {8'h55, 8'hAA};

        // Idle blank stream, then switch to source 1 mid-frame.
        repeat (3) frame(4, 2, -1, 0, 1);
        frame(4, 2, 3, 1, 1);
        repeat (2) frame(4, 2, -1, 0, 1);

        // Drain across back-to-back frames: 1 -> 0 -> 1 with no gaps.
        src_resp_red = {8'h11, 8'hAA};
        frame(4, 2, 2, 0, 0);
        frame(4, 2, 5, 1, 0);
        frame(4, 2, -1, 0, 0);

        // Same-source request, then out-of-range (blank) target.
        frame(4, 2, 1, 1, 1);
        frame(4, 2, 4, 5, 1);
        frame(4, 2, -1, 0, 1);

        // sof without en while pending must not switch.
        frame(4, 2, 2, 0, 1);
        drive(0, 1, 1, 0, 0);
        drive(0, 1, 0, 0, 0);
        frame(4, 2, -1, 0, 1);

        // Reset while pending with pixels in flight.
        frame(4, 1, 1, 1, 0);
        drive(1, 0, 0, 0, 0);
        rstn = 1'b0;
        drive(1, 0, 0, 0, 0);
        rstn = 1'b1;
        drive(0, 0, 0, 0, 0);
        drive(1, 1, 1, 0, 0);

        // Randomized traffic with random cfg, sources data and resets.
        rand_data = 1'b1;
        for (int f = 0; f < 300; f++) begin
            int w = $urandom_range(1, 6);
            int h = $urandom_range(1, 3);
            int k = 0;
            for (int y = 0; y < h; y++) begin
                for (int x = 0; x < w; x++) begin
                    while ($urandom_range(0, 3) == 0)
                        drive(0, $urandom_range(0, 5) == 0, 0,
                              $urandom_range(0, 7) == 0, $urandom_range(0, 7));
                    drive(1, (x == 0 && y == 0), (x == 0),
                          $urandom_range(0, 9) == 0, $urandom_range(0, 7));
                    k++;
                end
            end
            if ($urandom_range(0, 60) == 0) begin
                rstn = 1'b0;
                drive(1, 0, 0, 0, 0);
                rstn = 1'b1;
            end
        end

`ifdef HDMI_SRC_SCHED_STATS_EN
        // Frame counter wrap: 65537 single-pixel frames after reset.
        rand_data = 1'b0;
        rstn = 1'b0;
        drive(0, 0, 0, 0, 0);
        rstn = 1'b1;
        repeat (65537) drive(1, 1, 1, 0, 0);
        drive(0, 0, 0, 0, 0);
        check("frame_cnt_wrap", frame_cnt, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
